mmio_bridge: RTL and testbench
==============================

MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter DATA_W, 32, data width of CPU and peripheral buses.
REQ-002 Parameter ADDR_W, 32, CPU address width.
REQ-003 Parameter N_CH, 4, peripheral channel count, 1..16.
REQ-004 Parameter SPAN_LOG2, 4, log2 bytes per channel window.
REQ-005 Parameter BASE, 32'hFFFF_FC00, IO window base, aligned to 2^(SPAN_LOG2+clog2(N_CH)).
REQ-006 Parameter TIMEOUT, 15, max ACCESS cycles without ack, 1..255.
REQ-007 clk input 1 single system clock, all state on rising edge.
REQ-008 rst input 1 asynchronous active-high reset.
REQ-009 cpu_req input 1 access request, held until cpu_ready.
REQ-010 cpu_we input 1 1=write, 0=read.
REQ-011 cpu_addr input ADDR_W byte address.
REQ-012 cpu_wdata input DATA_W write data.
REQ-013 cpu_rdata output DATA_W read data, valid with cpu_ready.
REQ-014 cpu_ready output 1 one-cycle completion pulse.
REQ-015 cpu_err output 1 error flag, valid with cpu_ready.
REQ-016 p_sel output N_CH one-hot channel select.
REQ-017 p_we output 1 peripheral write strobe qualifier.
REQ-018 p_addr output SPAN_LOG2 offset within channel window.
REQ-019 p_wdata output DATA_W peripheral write data.
REQ-020 p_rdata input N_CH*DATA_W flat read data, channel i at [i*DATA_W +: DATA_W].
REQ-021 p_ack input N_CH per-channel access acknowledge.
REQ-022 err_cnt output 8 saturating error count.

Function
REQ-023 FSM states IDLE, ACCESS, DONE; IDLE after reset.
REQ-024 IDLE with cpu_req=1: address, we, wdata registered; hit -> ACCESS, miss -> DONE with error.
REQ-025 Hit = cpu_addr upper bits above SPAN_LOG2+clog2(N_CH) equal BASE's, and channel index cpu_addr[SPAN_LOG2 +: clog2(N_CH)] < N_CH.
REQ-026 ACCESS: p_sel one-hot at latched index, p_we/p_addr/p_wdata from latched values, all stable for whole ACCESS.
REQ-027 ACCESS with p_ack[ch]=1: capture p_rdata slice of ch (0 on write), -> DONE, err=0.
REQ-028 p_ack of non-selected channels ignored.
REQ-029 Wait counter cleared on ACCESS entry, increments per ACCESS cycle without ack; reaching TIMEOUT -> DONE with err=1, rdata=0.
REQ-030 Ack in same cycle counter reaches TIMEOUT: ack wins, no error.
REQ-031 DONE: cpu_ready=1 exactly one cycle, cpu_rdata/cpu_err registered, p_sel=0; next state IDLE.
REQ-032 Minimum latency: req in cycle 0, ack in cycle 1, cpu_ready in cycle 2.
REQ-033 cpu_req in DONE or ACCESS ignored; new request sampled only in IDLE.
REQ-034 p_sel, p_we zero in IDLE and DONE.
REQ-035 err_cnt increments on every error completion, saturates at 255.

Reset
REQ-036 rst asynchronously forces IDLE; cpu_ready, cpu_err, cpu_rdata, p_sel, p_we, p_addr, p_wdata, wait counter, err_cnt to 0.
REQ-037 rst mid-ACCESS aborts access with no cpu_ready pulse; first request after release is served normally.

Structure
REQ-038 FSM state encoding and default BASE constant in shared package cpu_pkg.
REQ-039 Address decode (hit, channel index) in one combinational sub-module mmio_decode; rest in mmio_bridge.

Verification
REQ-040 Read 0xFFFF_FC14, ch1 acks cycle 1 with 0x0000_00A5 -> p_sel=4'b0010, p_addr=4'h4, cpu_ready cycle 2, cpu_rdata=0xA5, cpu_err=0.
REQ-041 Write 0x1234 to 0xFFFF_FC30, ch3 acks after 3 cycles -> p_we=1, p_wdata=0x1234 held 4 cycles, cpu_ready one cycle, cpu_err=0.
REQ-042 Read 0x0000_1000 -> no p_sel, cpu_ready cycle 1, cpu_err=1, err_cnt=1.
REQ-043 Read 0xFFFF_FC20, ch2 never acks -> cpu_ready after 15 ACCESS cycles, cpu_err=1, cpu_rdata=0.
REQ-044 Assert rst during ACCESS wait cycle 2 -> p_sel=0 immediately, no cpu_ready; subsequent read served in 3 cycles.
REQ-045 300 out-of-window requests -> err_cnt=255.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side MMIO path.
//   state_t      : bridge FSM state encoding (IDLE / ACCESS / DONE)
//   DEFAULT_BASE : default base address of the IO window
//   idx_width    : width of a channel index for a given channel count, at least 1
//   sat_inc8     : saturating increment for 8-bit counters
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_FC00;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Bus bundle between the CPU, the bridge and the peripheral channels.
//   CPU side       : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ready, cpu_err
//   Peripheral side: p_sel, p_we, p_addr, p_wdata -> p_rdata (flat, channel i at
//                    [i*DATA_W +: DATA_W]), p_ack (one bit per channel)
//   modport slave  : the bridge
//   modport master : the environment (CPU plus peripherals)
interface mmio_bridge_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int N_CH      = 4,
  parameter int SPAN_LOG2 = 4
);

  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     cpu_ready;
  logic                     cpu_err;

  logic [N_CH-1:0]          p_sel;
  logic                     p_we;
  logic [SPAN_LOG2-1:0]     p_addr;
  logic [DATA_W-1:0]        p_wdata;
  logic [N_CH*DATA_W-1:0]   p_rdata;
  logic [N_CH-1:0]          p_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, p_rdata, p_ack,
    output cpu_rdata, cpu_ready, cpu_err, p_sel, p_we, p_addr, p_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, p_rdata, p_ack,
    input  cpu_rdata, cpu_ready, cpu_err, p_sel, p_we, p_addr, p_wdata
  );

endinterface

// File: rtl/mmio_decode.sv
// Combinational IO-window decoder.
//   addr   : CPU byte address
//   hit    : address falls inside the window and selects an existing channel
//   ch_idx : channel index taken from the bits just above the per-channel offset
module mmio_decode
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                N_CH      = 4,
  parameter int                SPAN_LOG2 = 4,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEFAULT_BASE),
  localparam int               IDX_W     = idx_width(N_CH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  ch_idx
);

  // With a single channel there are no index bits; the tag starts right above the offset.
  localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 0;
  localparam int TAG_LSB = SPAN_LOG2 + CH_BITS;
  localparam logic [IDX_W:0] N_CH_L = (IDX_W + 1)'(N_CH);

  logic tag_hit;
  logic unused_offset;

  generate
    if (N_CH > 1) begin : g_idx
      assign ch_idx = addr[SPAN_LOG2 +: IDX_W];
    end else begin : g_idx_single
      assign ch_idx = '0;
    end
  endgenerate

  assign tag_hit = (addr[ADDR_W-1:TAG_LSB] == BASE[ADDR_W-1:TAG_LSB]);
  // Non-power-of-two channel counts leave holes at the top of the window.
  assign hit     = tag_hit && ({1'b0, ch_idx} < N_CH_L);

  // The byte offset inside a channel window plays no part in the decode.
  assign unused_offset = ^addr[SPAN_LOG2-1:0];

endmodule

// File: rtl/mmio_bridge.sv
// Single-outstanding bridge from a CPU request/ready bus onto N_CH peripheral
// channels with one-hot select and per-channel acknowledge.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mmio_bridge_if.slave (CPU request side and peripheral side)
//   err_cnt  : saturating count of completions that returned an error
// Misses complete one cycle after the request; hits wait for the selected
// channel's ack or give up after TIMEOUT cycles in ACCESS.
module mmio_bridge
  import cpu_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                N_CH      = 4,
  parameter int                SPAN_LOG2 = 4,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEFAULT_BASE),
  parameter int                TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  mmio_bridge_if.slave       bus,
  output logic [7:0]         err_cnt
);

  localparam int IDX_W = idx_width(N_CH);

  state_t             state;
  logic [IDX_W-1:0]   ch_reg;
  logic [7:0]         wait_cnt;
  logic [7:0]         wait_next;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [N_CH-1:0]    sel_onehot;
  logic [DATA_W-1:0]  ch_data [N_CH];
  logic               ch_ack;
  logic [DATA_W-1:0]  ch_rdata;

  mmio_decode #(
    .ADDR_W    (ADDR_W),
    .N_CH      (N_CH),
    .SPAN_LOG2 (SPAN_LOG2),
    .BASE      (BASE)
  ) u_decode (
    .addr   (bus.cpu_addr),
    .hit    (dec_hit),
    .ch_idx (dec_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign sel_onehot[gi] = (dec_idx == IDX_W'(gi));
      assign ch_data[gi]    = bus.p_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Only the latched channel's ack and data matter; other channels are ignored.
  assign ch_ack    = bus.p_ack[ch_reg];
  assign ch_rdata  = ch_data[ch_reg];
  assign wait_next = wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ch_reg        <= '0;
      wait_cnt      <= '0;
      err_cnt       <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.p_sel     <= '0;
      bus.p_we      <= 1'b0;
      bus.p_addr    <= '0;
      bus.p_wdata   <= '0;
    end else begin
      bus.cpu_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            ch_reg      <= dec_idx;
            wait_cnt    <= '0;
            bus.p_addr  <= bus.cpu_addr[SPAN_LOG2-1:0];
            bus.p_wdata <= bus.cpu_wdata;
            if (dec_hit) begin
              bus.p_sel <= sel_onehot;
              bus.p_we  <= bus.cpu_we;
              state     <= ST_ACCESS;
            end else begin
              bus.cpu_ready <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= '0;
              err_cnt       <= sat_inc8(err_cnt);
              state         <= ST_DONE;
            end
          end
        end

        ST_ACCESS: begin
          // Ack is checked first so an ack on the final allowed cycle still succeeds.
          if (ch_ack) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= bus.p_we ? '0 : ch_rdata;
            bus.p_sel     <= '0;
            bus.p_we      <= 1'b0;
            state         <= ST_DONE;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next == 8'(TIMEOUT)) begin
              bus.cpu_ready <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= '0;
              bus.p_sel     <= '0;
              bus.p_we      <= 1'b0;
              err_cnt       <= sat_inc8(err_cnt);
              state         <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;

  mmio_bridge_if #(.DATA_W(32), .ADDR_W(32), .N_CH(4), .SPAN_LOG2(4)) bus ();

  mmio_bridge #(
    .DATA_W(32), .ADDR_W(32), .N_CH(4), .SPAN_LOG2(4),
    .BASE(32'hFFFF_FC00), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: expected completions in issue order
  logic [31:0] exp_rdata_q [$];
  logic        exp_err_q   [$];
  int          exp_id_q    [$];
  int          txn_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Monitor: one compare set per cpu_ready pulse
  logic        prev_ready = 1'b0;
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_id;

  always @(negedge clk) begin
    if (bus.cpu_ready === 1'b1) begin
      check("ready_single_pulse", {31'b0, prev_ready}, 32'd0);
      if (exp_rdata_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: cpu_ready with no pending request, required none");
      end else begin
        m_rdata = exp_rdata_q.pop_front();
        m_err   = exp_err_q.pop_front();
        m_id    = exp_id_q.pop_front();
        $display("txn %0d: rdata=0x%08h err=%0b (expect 0x%08h/%0b) err_cnt=%0d",
                 m_id, bus.cpu_rdata, bus.cpu_err, m_rdata, m_err, err_cnt);
        check($sformatf("txn%0d_rdata", m_id), bus.cpu_rdata, m_rdata);
        check($sformatf("txn%0d_err", m_id), {31'b0, bus.cpu_err}, {31'b0, m_err});
      end
    end
    prev_ready = bus.cpu_ready;
  end

  // Drive one CPU access and act as the peripherals. Called at posedge+#1 with
  // the bridge in IDLE; returns at posedge+#1 one idle cycle after completion.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int ack_at, input logic [1:0] ack_ch, input logic [31:0] ack_data,
                         input logic [3:0] noise, input logic [3:0] exp_sel, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int          cyc;
    bit          done;
    logic [3:0]  ch_bit;
    logic [127:0] rd;
    exp_rdata_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    exp_id_q.push_back(txn_id);
    ch_bit        = 4'b0001 << ack_ch;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.p_ack     = 4'b0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.cpu_ready === 1'b1) begin
        done = 1;
        check($sformatf("txn%0d_latency", txn_id), 32'(cyc), 32'(exp_lat));
        check($sformatf("txn%0d_sel_done", txn_id), {28'b0, bus.p_sel}, 32'd0);
        bus.cpu_req = 1'b0;
        bus.p_ack   = 4'b0;
      end else begin
        check($sformatf("txn%0d_p_sel", txn_id), {28'b0, bus.p_sel}, {28'b0, exp_sel});
        check($sformatf("txn%0d_p_we", txn_id), {31'b0, bus.p_we}, {31'b0, we});
        check($sformatf("txn%0d_p_addr", txn_id), {28'b0, bus.p_addr}, {28'b0, addr[3:0]});
        check($sformatf("txn%0d_p_wdata", txn_id), bus.p_wdata, wdata);
        for (int i = 0; i < 4; i++) rd[i*32 +: 32] = 32'hBAD0_0000 + 32'(i);
        if (cyc - 1 == ack_at) begin
          rd[ack_ch*32 +: 32] = ack_data;
          bus.p_ack = (noise & ~ch_bit) | ch_bit;
        end else begin
          bus.p_ack = noise & ~ch_bit;
        end
        bus.p_rdata = rd;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL txn%0d_timeout: no cpu_ready within 40 cycles, required by cycle %0d", txn_id, exp_lat);
      bus.cpu_req = 1'b0;
      bus.p_ack   = 4'b0;
    end
    txn_id++;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.p_rdata   = '0;
    bus.p_ack     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", {31'b0, bus.cpu_ready}, 32'd0);
    check("rst_cpu_err",   {31'b0, bus.cpu_err}, 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_p_sel",     {28'b0, bus.p_sel}, 32'd0);
    check("rst_p_we",      {31'b0, bus.p_we}, 32'd0);
    check("rst_p_addr",    {28'b0, bus.p_addr}, 32'd0);
    check("rst_p_wdata",   bus.p_wdata, 32'd0);
    check("rst_err_cnt",   {24'b0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // addr, we, wdata, ack_at, ack_ch, ack_data, noise, exp_sel, exp_lat, exp_rdata, exp_err
    run_txn(32'hFFFF_FC14, 1'b0, 32'h0,         0, 2'd1, 32'h0000_00A5, 4'b1101, 4'b0010,  2, 32'h0000_00A5, 1'b0);
    run_txn(32'hFFFF_FC30, 1'b1, 32'h0000_1234, 3, 2'd3, 32'hDEAD_BEEF, 4'b0111, 4'b1000,  5, 32'h0,         1'b0);
    check("err_cnt_after_hits", {24'b0, err_cnt}, 32'd0);
    run_txn(32'h0000_1000, 1'b0, 32'h0,        -1, 2'd0, 32'h0,         4'b0000, 4'b0000,  1, 32'h0,         1'b1);
    check("err_cnt_after_miss", {24'b0, err_cnt}, 32'd1);
    run_txn(32'hFFFF_FBFC, 1'b0, 32'h0,        -1, 2'd0, 32'h0,         4'b0000, 4'b0000,  1, 32'h0,         1'b1);
    run_txn(32'hFFFF_FC40, 1'b1, 32'h0000_0077,-1, 2'd0, 32'h0,         4'b0000, 4'b0000,  1, 32'h0,         1'b1);
    check("err_cnt_after_edges", {24'b0, err_cnt}, 32'd3);
    run_txn(32'hFFFF_FC20, 1'b0, 32'h0,        -1, 2'd2, 32'h0,         4'b1011, 4'b0100, 16, 32'h0,         1'b1);
    check("err_cnt_after_timeout", {24'b0, err_cnt}, 32'd4);
    run_txn(32'hFFFF_FC08, 1'b0, 32'h0,        14, 2'd0, 32'h5555_AAAA, 4'b1110, 4'b0001, 16, 32'h5555_AAAA, 1'b0);
    check("err_cnt_ack_at_limit", {24'b0, err_cnt}, 32'd4);

    // Reset during the third ACCESS wait cycle
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'hFFFF_FC24;
    bus.p_ack    = 4'b0;
    @(posedge clk); #1;
    check("abort_sel_before", {28'b0, bus.p_sel}, 32'h4);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_sel_immediate", {28'b0, bus.p_sel}, 32'd0);
    check("abort_no_ready", {31'b0, bus.cpu_ready}, 32'd0);
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_err_cnt_cleared", {24'b0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_still_no_ready", {31'b0, bus.cpu_ready}, 32'd0);
    run_txn(32'hFFFF_FC1C, 1'b0, 32'h0,         1, 2'd1, 32'h1357_9BDF, 4'b0000, 4'b0010,  3, 32'h1357_9BDF, 1'b0);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      run_txn(32'h0000_1000 + 32'(i * 4), 1'b0, 32'h0, -1, 2'd0, 32'h0, 4'b0000, 4'b0000, 1, 32'h0, 1'b1);
    end
    check("err_cnt_saturated", {24'b0, err_cnt}, 32'd255);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_rdata_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
